id_decode_buf: RTL and testbench

ID_DECODE_BUF -- requirements
Module: id_decode_buf

---
 rtl/id_decode_buf.sv | 187 ++++++++++++++++++
 tb/tb_id_decode_buf.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_buf.sv
// Instruction buffer + decoder between fetch and EX.
// Fetched {inst, pc} pairs are queued in a DEPTH-entry circular buffer. The
// head entry is decoded combinationally and handed to EX, unless it reads a
// register that a load currently in EX is about to write.
module id_decode_buf #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_resp,
  input  logic [31:0]     imem_rdata,
  input  logic [PC_W-1:0] imem_pc,
  output logic            in_ready,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
  output logic            out_valid,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [63:0]     out_order,
  output logic [4:0]      rs1_s,
  output logic [4:0]      rs2_s,
  output logic [4:0]      rd_s,
  output logic [31:0]     imm,
  output logic            regf_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            is_branch,
  output logic            is_jump,
  output logic            illegal,
  output logic [$clog2(DEPTH):0] count,
  output logic            overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   cnt;
  logic [63:0]     order;
  logic            ovf;

  logic push, pop, stall, vld;
  logic [31:0] hi;

  // decode scratch
  logic        known, wr, use1, use2, d_re, d_we, d_br, d_jmp;
  logic [31:0] d_imm;
  logic [4:0]  d_rd, d_rs1, d_rs2;

  assign in_ready = (cnt < CW'(DEPTH));
  assign push     = imem_resp && in_ready && !flush;
  assign pop      = vld && ex_ready;
  assign hi       = inst_mem[head];

  // Storage is data-only; it is never read while the entry count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= imem_rdata;
      pc_mem[tail]   <= imem_pc;
    end
  end

  // Pointers, occupancy and retire order; flush wins over push/pop.
  // DEPTH is a power of two so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      order <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) begin
        head  <= head + 1'b1;
        order <= order + 64'd1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky record of a fetch response that arrived with no room for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        ovf <= 1'b0;
    else if (imem_resp && !in_ready) ovf <= 1'b1;
  end

  // Opcode decode of the head entry, including immediate format selection.
  always_comb begin
    known = 1'b1;
    wr    = 1'b0;
    use1  = 1'b1;
    use2  = 1'b0;
    d_re  = 1'b0;
    d_we  = 1'b0;
    d_br  = 1'b0;
    d_jmp = 1'b0;
    d_imm = '0;
    case (hi[6:0])
      OP_LUI, OP_AUIPC: begin
        wr = 1'b1; use1 = 1'b0;
        d_imm = {hi[31:12], 12'h000};
      end
      OP_JAL: begin
        wr = 1'b1; use1 = 1'b0; d_jmp = 1'b1;
        d_imm = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
      end
      OP_JALR: begin
        wr = 1'b1; d_jmp = 1'b1;
        d_imm = {{20{hi[31]}}, hi[31:20]};
      end
      OP_BR: begin
        use2 = 1'b1; d_br = 1'b1;
        d_imm = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
      end
      OP_LOAD: begin
        wr = 1'b1; d_re = 1'b1;
        d_imm = {{20{hi[31]}}, hi[31:20]};
      end
      OP_STORE: begin
        use2 = 1'b1; d_we = 1'b1;
        d_imm = {{20{hi[31]}}, hi[31:25], hi[11:7]};
      end
      OP_IMM: begin
        wr = 1'b1;
        d_imm = {{20{hi[31]}}, hi[31:20]};
      end
      OP_REG: begin
        wr = 1'b1; use2 = 1'b1;
      end
      default: known = 1'b0;
    endcase
    d_rs1 = use1 ? hi[19:15] : 5'd0;
    d_rs2 = use2 ? hi[24:20] : 5'd0;
    d_rd  = wr   ? hi[11:7]  : 5'd0;
  end

  // Load-use hazard: hold the head while EX's load targets one of its sources.
  always_comb begin
    stall = ex_load_valid && (ex_load_rd != 5'd0) &&
            ((use1 && ex_load_rd == hi[19:15]) || (use2 && ex_load_rd == hi[24:20]));
    vld   = (cnt != '0) && !stall && !flush;
  end

  // Present the decoded head; everything reads as zero while nothing is offered.
  always_comb begin
    out_valid = vld;
    out_inst  = vld ? hi : 32'd0;
    out_pc    = vld ? pc_mem[head] : '0;
    rs1_s     = vld ? d_rs1 : 5'd0;
    rs2_s     = vld ? d_rs2 : 5'd0;
    rd_s      = vld ? d_rd  : 5'd0;
    imm       = vld ? d_imm : 32'd0;
    regf_we   = vld && wr && (d_rd != 5'd0);
    mem_re    = vld && d_re;
    mem_we    = vld && d_we;
    is_branch = vld && d_br;
    is_jump   = vld && d_jmp;
    illegal   = vld && !known;
  end

  assign out_order = order;
  assign count     = cnt;
  assign overflow  = ovf;

endmodule

// File: tb/tb_id_decode_buf.sv
// Randomized + directed bench for id_decode_buf with a queue-based reference.
module tb_id_decode_buf;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_resp = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic [PC_W-1:0] imem_pc = '0;
  logic            in_ready;
  logic            flush = 1'b0;
  logic            ex_ready = 1'b0;
  logic            ex_load_valid = 1'b0;
  logic [4:0]      ex_load_rd = '0;
  logic            out_valid;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic [63:0]     out_order;
  logic [4:0]      rs1_s, rs2_s, rd_s;
  logic [31:0]     imm;
  logic            regf_we, mem_re, mem_we, is_branch, is_jump, illegal;
  logic [$clog2(DEPTH):0] count;
  logic            overflow;

  id_decode_buf #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .imem_pc(imem_pc), .in_ready(in_ready), .flush(flush), .ex_ready(ex_ready),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_order(out_order), .rs1_s(rs1_s),
    .rs2_s(rs2_s), .rd_s(rd_s), .imm(imm), .regf_we(regf_we), .mem_re(mem_re),
    .mem_we(mem_we), .is_branch(is_branch), .is_jump(is_jump), .illegal(illegal),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    bit          u1, u2, wr, we, re, mwe, br, jmp, ill;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mord = '0;
  bit          movf = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the RV32I encoding tables.
  function automatic exp_t dec(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    e = '{inst: i, pc: pc, rs1: 0, rs2: 0, rd: 0, imm: 0, u1: 1, u2: 0, wr: 0,
          we: 0, re: 0, mwe: 0, br: 0, jmp: 0, ill: 0};
    case (i[6:0])
      7'h37, 7'h17: begin e.u1 = 0; e.wr = 1; e.imm = i & 32'hFFFFF000; end
      7'h6F: begin
        e.u1 = 0; e.wr = 1; e.jmp = 1;
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.imm = 32'(int'(j21));
      end
      7'h67: begin e.wr = 1; e.jmp = 1; e.imm = 32'($signed(i) >>> 20); end
      7'h63: begin
        e.u2 = 1; e.br = 1;
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.imm = 32'(int'(b13));
      end
      7'h03: begin e.wr = 1; e.re = 1; e.imm = 32'($signed(i) >>> 20); end
      7'h23: begin
        e.u2 = 1; e.mwe = 1;
        s12 = {i[31:25], i[11:7]};
        e.imm = 32'(int'(s12));
      end
      7'h13: begin e.wr = 1; e.imm = 32'($signed(i) >>> 20); end
      7'h33: begin e.wr = 1; e.u2 = 1; end
      default: e.ill = 1;
    endcase
    e.rs1 = e.u1 ? i[19:15] : 5'd0;
    e.rs2 = e.u2 ? i[24:20] : 5'd0;
    e.rd  = e.wr ? i[11:7]  : 5'd0;
    e.we  = e.wr && (e.rd != 0);
    return e;
  endfunction

  function automatic bit model_valid();
    bit st;
    if (q.size() == 0 || flush) return 0;
    st = ex_load_valid && ex_load_rd != 0 &&
         ((q[0].u1 && q[0].rs1 == ex_load_rd) || (q[0].u2 && q[0].rs2 == ex_load_rd));
    return !st;
  endfunction

  // Reference buffer: queue of pre-decoded entries updated at each clock edge.
  initial forever begin
    bit v, psh;
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete(); mord = '0; movf = 0;
    end else begin
      v   = model_valid();
      psh = imem_resp && (q.size() < DEPTH);
      if (imem_resp && q.size() >= DEPTH) movf = 1;
      if (flush) q.delete();
      else begin
        if (v && ex_ready) begin void'(q.pop_front()); mord = mord + 1; end
        if (psh) q.push_back(dec(imem_rdata, imem_pc));
      end
    end
  end

  // Monitor: compare the presented head and status against the reference.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      chk("rst_count", 64'(count), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_overflow", 64'(overflow), 0);
    end else begin
      chk("count", 64'(count), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("overflow", 64'(overflow), 64'(movf));
      chk("out_valid", 64'(out_valid), 64'(model_valid()));
      if (model_valid()) begin
        e = q[0];
        chk("inst", 64'(out_inst), 64'(e.inst));
        chk("pc", 64'(out_pc), 64'(e.pc));
        chk("order", out_order, mord);
        chk("rs1", 64'(rs1_s), 64'(e.rs1));
        chk("rs2", 64'(rs2_s), 64'(e.rs2));
        chk("rd", 64'(rd_s), 64'(e.rd));
        chk("imm", 64'(imm), 64'(e.imm));
        chk("ctl", 64'({regf_we, mem_re, mem_we, is_branch, is_jump, illegal}),
            64'({e.we, e.re, e.mwe, e.br, e.jmp, e.ill}));
      end else begin
        chk("idle_inst", 64'(out_inst), 0);
        chk("idle_dec", 64'({rs1_s, rs2_s, rd_s, imm}), 0);
        chk("idle_ctl", 64'({regf_we, mem_re, mem_we, is_branch, is_jump, illegal}), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    imem_resp = 0; flush = 0; ex_load_valid = 0; ex_ready = 1;
    for (int k = 0; k < 40 && q.size() != 0; k++) step();
    chk("drain_empty", 64'(q.size()), 0);
    ex_ready = 0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h7F, 7'h73};
    logic [31:0] r;
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 10)];
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    r[11:7]  = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    logic [63:0] ord_before;
    #12 rst = 1'b1;
    step();

    // addi x1,x0,5
    imem_resp = 1; imem_rdata = 32'h00500093; imem_pc = 32'h1000; ex_ready = 1;
    step();
    imem_resp = 0;
    @(negedge clk);
    chk("addi_valid", 64'(out_valid), 1);
    chk("addi_rd", 64'(rd_s), 1);
    chk("addi_imm", 64'(imm), 5);
    chk("addi_we", 64'(regf_we), 1);
    chk("addi_order", out_order, 0);
    step();

    // fill, then one response too many
    ex_ready = 0;
    for (int k = 0; k < DEPTH; k++) begin
      imem_resp = 1; imem_rdata = 32'h00000013 | (32'(k) << 20); imem_pc = 32'h2000 + 32'(4*k);
      step();
    end
    imem_resp = 0;
    @(negedge clk);
    chk("full_count", 64'(count), DEPTH);
    chk("full_in_ready", 64'(in_ready), 0);
    step();
    imem_resp = 1; imem_rdata = 32'h00100113; imem_pc = 32'h3000;
    step();
    imem_resp = 0;
    @(negedge clk);
    chk("ovf_set", 64'(overflow), 1);
    chk("ovf_count", 64'(count), DEPTH);
    drain();

    // load-use stall on add x3,x1,x2
    imem_resp = 1; imem_rdata = 32'h002081B3; imem_pc = 32'h4000;
    ex_load_valid = 1; ex_load_rd = 2;
    step();
    imem_resp = 0;
    @(negedge clk);
    chk("stall_hold", 64'(out_valid), 0);
    step();
    ex_load_valid = 0;
    @(negedge clk);
    chk("stall_release", 64'(out_valid), 1);
    drain();

    // flush with a simultaneous fetch response
    for (int k = 0; k < 3; k++) begin
      imem_resp = 1; imem_rdata = 32'h00000033; imem_pc = 32'h5000 + 32'(4*k);
      step();
    end
    ord_before = mord;
    flush = 1; imem_resp = 1; imem_pc = 32'h5100;
    step();
    flush = 0; imem_resp = 0;
    @(negedge clk);
    chk("flush_count", 64'(count), 0);
    chk("flush_valid", 64'(out_valid), 0);
    step();
    imem_resp = 1; imem_rdata = 32'h00000013; imem_pc = 32'h5200; ex_ready = 1;
    step();
    imem_resp = 0;
    @(negedge clk);
    chk("flush_order", out_order, ord_before);
    drain();

    // branch and illegal decode
    imem_resp = 1; imem_rdata = 32'hFE208CE3; imem_pc = 32'h6000; ex_ready = 1;
    step();
    imem_rdata = 32'hFFFFFFFF; imem_pc = 32'h6004;
    @(negedge clk);
    chk("beq_branch", 64'(is_branch), 1);
    chk("beq_imm", 64'(imm), 64'h0000_0000_FFFF_FFF8);
    chk("beq_we", 64'(regf_we), 0);
    step();
    imem_resp = 0;
    @(negedge clk);
    chk("ill_flag", 64'(illegal), 1);
    chk("ill_we", 64'(regf_we), 0);
    drain();

    // reset in the middle of traffic
    imem_resp = 1; imem_rdata = 32'h00000013; ex_ready = 0;
    step(); step();
    #2 rst = 0;
    @(negedge clk);
    step();
    rst = 1; imem_resp = 0;
    step();

    // streaming push+pop across several wraps
    ex_ready = 1;
    for (int k = 0; k < 12; k++) begin
      imem_resp = 1; imem_rdata = 32'h00000013 | (32'(k) << 20); imem_pc = 32'h7000 + 32'(4*k);
      step();
      @(negedge clk);
      chk("stream_count", 64'(count), 1);
      chk("stream_order", out_order, 64'(k));
      chk("stream_pc", 64'(out_pc), 64'(32'h7000 + 32'(4*k)));
    end
    drain();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      imem_resp     = ($urandom_range(0, 9) < 6);
      imem_rdata    = rand_inst();
      imem_pc       = $urandom;
      ex_ready      = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 39) == 0);
      ex_load_valid = ($urandom_range(0, 9) < 4);
      ex_load_rd    = 5'($urandom_range(0, 3));
      step();
    end
    drain();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
